avmm_sdram_write_wrapper: RTL and testbench

AVMM_SDRAM_WRITE_WRAPPER -- requirements
Module: avmm_sdram_write_wrapper

---
 rtl/avmm_sdram_write_wrapper.sv | 140 ++++++++++++++
 tb/tb_avmm_sdram_write_wrapper.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_sdram_write_wrapper.sv
// Streams write_cnt user beats into Avalon-MM bursts of up to MAX_BURST beats.
// Optional macro AVMM_WRITE_STALL_CNT_EN adds the stall_cnt waitrequest counter.
module avmm_sdram_write_wrapper #(
    parameter int MAX_BURST = 64,
    parameter int DATA_W    = 128
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                write_start,
    input  logic [31:0]         write_addr,
    input  logic [10:0]         write_cnt,
    input  logic [DATA_W-1:0]   write_data,
    output logic                write_nxt,
    output logic                write_done,
    output logic [31:0]         avm_address,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [6:0]          avm_burstcount,
`ifdef AVMM_WRITE_STALL_CNT_EN
    output logic [31:0]         stall_cnt,
`endif
    input  logic                avm_waitrequest
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam logic [10:0] MAX_B = 11'(MAX_BURST);

    state_t              state_q;
    logic [10:0]         beats_left_q;  // beats of the transfer not yet accepted
    logic [6:0]          burst_left_q;  // beats of the current burst not yet accepted
    logic [31:0]         addr_q;
    logic [6:0]          bc_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                wr_q;
    logic                done_q;

    logic                accept;
    logic                last_beat;
    logic [10:0]         rem_after_d;
    logic [6:0]          next_bc_d;
    logic                unused_addr_lsbs;

    assign unused_addr_lsbs = ^write_addr[3:0];

    assign accept    = (state_q == WRITE) && !avm_waitrequest;
    assign last_beat = (beats_left_q == 11'd1);

    // Beats still owed after this cycle; sizes the burst loaded in LOAD or at a burst boundary.
    assign rem_after_d = (state_q == LOAD) ? beats_left_q : beats_left_q - 11'd1;
    assign next_bc_d   = (rem_after_d >= MAX_B) ? MAX_B[6:0] : rem_after_d[6:0];

    // The user beat is sampled on the same edge write_nxt is high, so this cannot be registered.
    assign write_nxt = (state_q == LOAD) || (accept && !last_beat);

    assign write_done     = done_q;
    assign avm_address    = addr_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_burstcount = bc_q;
    assign avm_byteenable = '1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            burst_left_q <= '0;
            addr_q       <= '0;
            bc_q         <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (write_start) begin
                        if (write_cnt != 11'd0) begin
                            addr_q       <= {write_addr[31:4], 4'b0000};
                            beats_left_q <= write_cnt;
                            state_q      <= LOAD;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                LOAD: begin
                    wdata_q      <= write_data;
                    bc_q         <= next_bc_d;
                    burst_left_q <= next_bc_d;
                    wr_q         <= 1'b1;
                    state_q      <= WRITE;
                end
                WRITE: begin
                    if (accept) begin
                        if (last_beat) begin
                            wr_q         <= 1'b0;
                            beats_left_q <= '0;
                            burst_left_q <= '0;
                            state_q      <= DONE;
                        end else begin
                            beats_left_q <= beats_left_q - 11'd1;
                            wdata_q      <= write_data;
                            if (burst_left_q == 7'd1) begin
                                addr_q       <= addr_q + {21'd0, bc_q, 4'b0000};
                                bc_q         <= next_bc_d;
                                burst_left_q <= next_bc_d;
                            end else begin
                                burst_left_q <= burst_left_q - 7'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AVMM_WRITE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (state_q == IDLE && write_start) begin
            stall_cnt_q <= '0;
        end else if (wr_q && avm_waitrequest && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avmm_sdram_write_wrapper.sv
// Directed bench: expected bus beats are queued per transfer and popped as the slave accepts them.
module tb_avmm_sdram_write_wrapper;

    localparam int DW = 128;

    typedef struct {
        logic [31:0] a;
        logic [6:0]  bc;
        logic [DW-1:0] d;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            write_start;
    logic [31:0]     write_addr;
    logic [10:0]     write_cnt;
    logic [DW-1:0]   write_data;
    logic            write_nxt;
    logic            write_done;
    logic [31:0]     avm_address;
    logic            avm_write;
    logic [DW-1:0]   avm_writedata;
    logic [DW/8-1:0] avm_byteenable;
    logic [6:0]      avm_burstcount;
    logic            avm_waitrequest;
`ifdef AVMM_WRITE_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    always #5 clk = ~clk;

    avmm_sdram_write_wrapper #(.MAX_BURST(64), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .write_start    (write_start),
        .write_addr     (write_addr),
        .write_cnt      (write_cnt),
        .write_data     (write_data),
        .write_nxt      (write_nxt),
        .write_done     (write_done),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_burstcount (avm_burstcount),
`ifdef AVMM_WRITE_STALL_CNT_EN
        .stall_cnt      (stall_cnt),
`endif
        .avm_waitrequest(avm_waitrequest)
    );

    function automatic logic [DW-1:0] dat(input logic [31:0] k);
        return {k, ~k, k ^ 32'h5A5A_5A5A, k + 32'h1234_5678};
    endfunction

    logic [31:0] user_idx = 32'd0;
    assign write_data = dat(user_idx);

    int checks = 0;
    int errors = 0;
    int cyc, acc, first_wr, done_cyc, done_n, nxt_n;
    bit prev_stall, nxt_seen;
    logic [31:0]   sv_addr;
    logic [6:0]    sv_bc;
    logic [DW-1:0] sv_data;
    beat_t exp_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor at the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        if (prev_stall) begin
            chk("hold_addr", 128'(avm_address), 128'(sv_addr));
            chk("hold_bc", 128'(avm_burstcount), 128'(sv_bc));
            chk("hold_data", avm_writedata, sv_data);
        end
        if (avm_write && avm_waitrequest) chk("stall_nxt", 128'(write_nxt), 128'(0));
        prev_stall = avm_write && avm_waitrequest;
        sv_addr = avm_address;
        sv_bc   = avm_burstcount;
        sv_data = avm_writedata;
        if (avm_write && !avm_waitrequest) begin
            acc++;
            if (exp_q.size() == 0) begin
                chk("extra_beat", 128'(1), 128'(0));
            end else begin
                e = exp_q.pop_front();
                chk("beat_addr", 128'(avm_address), 128'(e.a));
                chk("beat_bc", 128'(avm_burstcount), 128'(e.bc));
                chk("beat_data", avm_writedata, e.d);
            end
        end
        if (avm_write && first_wr < 0) first_wr = cyc;
        if (write_done) begin
            done_n++;
            done_cyc = cyc;
        end
        nxt_seen = write_nxt;
        if (write_nxt) nxt_n++;
        @(posedge clk);
        #1;
        cyc++;
        if (nxt_seen) user_idx = user_idx + 32'd1;
    endtask

    task automatic run_xfer(input logic [31:0] addr, input int cnt, input int stall_at,
                            input int stall_len, input int ign_at, input int abort_at);
        logic [31:0] a;
        logic [31:0] base;
        int rem, bc, idx, stalls, exp_done;
        exp_q.delete();
        base = user_idx;
        a = addr & 32'hFFFF_FFF0;
        rem = cnt;
        idx = 0;
        while (rem > 0) begin
            bc = (rem > 64) ? 64 : rem;
            for (int j = 0; j < bc; j++) begin
                exp_q.push_back('{a, 7'(bc), dat(base + 32'(idx))});
                idx++;
            end
            a = a + 32'(bc * 16);
            rem -= bc;
        end
        acc = 0; cyc = 0; first_wr = -1; done_cyc = -1; done_n = 0; nxt_n = 0;
        stalls = 0; prev_stall = 0;
        write_addr  = addr;
        write_cnt   = 11'(cnt);
        write_start = 1'b1;
        tick();
        write_start = 1'b0;
        write_addr  = 32'hDEAD_BEEF;
        while (done_n == 0 && cyc < 600) begin
            avm_waitrequest = (acc == stall_at && stalls < stall_len);
            if (avm_waitrequest && avm_write) stalls++;
            if (cyc == ign_at) begin
                write_start = 1'b1;
                write_cnt   = 11'd3;
                write_addr  = 32'h0000_8000;
            end else begin
                write_start = 1'b0;
            end
            if (acc == abort_at && avm_write) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rst_write", 128'(avm_write), 128'(0));
                chk("rst_nxt", 128'(write_nxt), 128'(0));
                chk("rst_done", 128'(write_done), 128'(0));
                chk("rst_addr", 128'(avm_address), 128'(0));
                chk("rst_bc", 128'(avm_burstcount), 128'(0));
                chk("rst_data", avm_writedata, 128'(0));
`ifdef AVMM_WRITE_STALL_CNT_EN
                chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
`endif
                repeat (3) tick();
                chk("abort_no_done", 128'(done_n), 128'(0));
                reset_n = 1'b1;
                avm_waitrequest = 1'b0;
                exp_q.delete();
                return;
            end
            tick();
        end
        avm_waitrequest = 1'b0;
        write_start = 1'b0;
        tick();
        tick();
        exp_done = (cnt == 0) ? 2 : cnt + 3 + ((stall_at >= 0 && stall_at < cnt) ? stall_len : 0);
        chk("done_pulses", 128'(done_n), 128'(1));
        chk("first_write_cyc", 128'(first_wr), (cnt == 0) ? 128'(-1) : 128'(2));
        chk("done_cyc", 128'(done_cyc), 128'(exp_done));
        chk("nxt_count", 128'(nxt_n), 128'(cnt));
        chk("beats_left", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        reset_n = 1'b0;
        write_start = 1'b0;
        write_addr = '0;
        write_cnt = '0;
        avm_waitrequest = 1'b0;
        #2;
        chk("reset_write", 128'(avm_write), 128'(0));
        chk("reset_nxt", 128'(write_nxt), 128'(0));
        chk("reset_done", 128'(write_done), 128'(0));
        chk("reset_addr", 128'(avm_address), 128'(0));
        chk("reset_bc", 128'(avm_burstcount), 128'(0));
        chk("reset_data", avm_writedata, 128'(0));
        chk("byteenable", 128'(avm_byteenable), 128'(16'hFFFF));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        cyc = 0; first_wr = -1; done_n = 0; nxt_n = 0; prev_stall = 0;
        tick();

        run_xfer(32'h0000_1000, 4, -1, 0, -1, -1);
        run_xfer(32'h0000_0000, 130, -1, 0, -1, -1);
        run_xfer(32'h0000_2008, 5, 1, 3, -1, -1);
`ifdef AVMM_WRITE_STALL_CNT_EN
        chk("stall_cnt", 128'(stall_cnt), 128'(3));
`endif
        run_xfer(32'h0000_3000, 0, -1, 0, -1, -1);
`ifdef AVMM_WRITE_STALL_CNT_EN
        chk("stall_cnt_clr", 128'(stall_cnt), 128'(0));
`endif
        run_xfer(32'h0000_4000, 10, -1, 0, -1, 4);
        run_xfer(32'h0000_5000, 3, -1, 0, -1, -1);
        run_xfer(32'h0000_6000, 6, -1, 0, 4, -1);
        run_xfer(32'hFFFF_FC0F, 66, -1, 0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
